// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_reg_target_if.sv
// Register-file side of the I2C target: pointer, write strobe and read data.
`timescale 1ns/1ps
interface i2c_reg_target_if;

  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_we_o;
  logic [7:0] reg_rdata_i;
  logic       addressed_o;

  modport master (
    output reg_addr_o,
    output reg_wdata_o,
    output reg_we_o,
    output addressed_o,
    input  reg_rdata_i
  );

  modport slave (
    input  reg_addr_o,
    input  reg_wdata_o,
    input  reg_we_o,
    input  addressed_o,
    output reg_rdata_i
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and decodes edge, START and STOP pulses.
`timescale 1ns/1ps
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Reset to the idle-bus level so no phantom edge appears when reset lifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda};
      scl_d  <= scl_sr[SYNC_STAGES-1];
      sda_d  <= sda_sr[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sr[SYNC_STAGES-1];
  assign sda_s    = sda_sr[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing an 8-bit register space with an auto-incrementing pointer.
`timescale 1ns/1ps
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [6:0]             assigned_address_i,
  input  logic                   scl_i,
  inout  wire                    sda_io,
  i2c_reg_target_if.master       reg_if
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       bus_start;
  logic       bus_stop;

  i2c_state_e state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic [7:0] tx_q;
  logic       rw_q;
  logic       sda_oe;
  logic       inc_pending;
  logic [7:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       reg_we_q;
  logic       addressed_q;
  logic [7:0] shift_next;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk_i),
    .rst      (rst_i),
    .scl      (scl_i),
    .sda      (sda_io),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (bus_start),
    .stop     (bus_stop)
  );

  assign shift_next = {shift_q[6:0], sda_s};
  assign sda_io     = sda_oe ? 1'b0 : 1'bz;

  assign reg_if.reg_addr_o  = reg_addr_q;
  assign reg_if.reg_wdata_o = reg_wdata_q;
  assign reg_if.reg_we_o    = reg_we_q;
  assign reg_if.addressed_o = addressed_q;

  // ACK states enter with SDA released, so sda_oe tells the 8th fall from the 9th.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      rw_q        <= I2C_RW_WRITE;
      sda_oe      <= 1'b0;
      inc_pending <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      if (inc_pending) begin
        reg_addr_q  <= reg_addr_q + 8'd1;
        inc_pending <= 1'b0;
      end
      if (bus_start) begin
        state       <= ADDR;
        bit_cnt     <= '0;
        sda_oe      <= 1'b0;
        addressed_q <= 1'b0;
      end else if (bus_stop) begin
        state       <= IDLE;
        sda_oe      <= 1'b0;
        addressed_q <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift_q <= shift_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift_next[7:1] == assigned_address_i) begin
                state       <= ADDR_ACK;
                rw_q        <= shift_next[0];
                addressed_q <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            bit_cnt <= '0;
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else if (rw_q == I2C_RW_READ) begin
              sda_oe <= ~reg_if.reg_rdata_i[7];
              tx_q   <= {reg_if.reg_rdata_i[6:0], 1'b0};
              state  <= RD_DATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= PTR;
            end
          end
          PTR: if (scl_rise) begin
            shift_q <= shift_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              reg_addr_q <= shift_next;
              state      <= PTR_ACK;
            end
          end
          PTR_ACK, WR_ACK: if (scl_fall) begin
            bit_cnt <= '0;
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end
          end
          WR_DATA: if (scl_rise) begin
            shift_q <= shift_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              reg_wdata_q <= shift_next;
              reg_we_q    <= 1'b1;
              inc_pending <= 1'b1;
              state       <= WR_ACK;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe      <= 1'b0;
              inc_pending <= 1'b1;
              bit_cnt     <= '0;
              state       <= RD_ACK;
            end else begin
              sda_oe  <= ~tx_q[7];
              tx_q    <= {tx_q[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          // Only an ACKed 9th rise lets the following fall reach the reload.
          RD_ACK: begin
            if (scl_rise && sda_s) begin
              state <= IGNORE;
            end else if (scl_fall) begin
              sda_oe  <= ~reg_if.reg_rdata_i[7];
              tx_q    <= {reg_if.reg_rdata_i[6:0], 1'b0};
              bit_cnt <= '0;
              state   <= RD_DATA;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench: bit-banged I2C controller against the register target.
`timescale 1ns/1ps
module tb_i2c_reg_target;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] assigned;
  logic       scl;
  logic       ctrl_low;
  wire        sda;

  logic [7:0] mem [256];
  int         total = 0;
  int         bad = 0;

  int         we_cnt = 0;
  int         drove_cnt = 0;
  int         run = 0;
  int         max_run = 0;
  logic [7:0] log_addr [16];
  logic [7:0] log_data [16];

  always #5 clk = ~clk;

  assign sda = ctrl_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_reg_target_if rif ();
  assign rif.reg_rdata_i = mem[rif.reg_addr_o];

  i2c_reg_target #(.SYNC_STAGES(2)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .assigned_address_i (assigned),
    .scl_i              (scl),
    .sda_io             (sda),
    .reg_if             (rif.master)
  );

  // Strobe log, pulse-width tracking and target-drive detection.
  always @(negedge clk) begin
    if (rif.reg_we_o === 1'b1) begin
      if (we_cnt < 16) begin
        log_addr[we_cnt] = rif.reg_addr_o;
        log_data[we_cnt] = rif.reg_wdata_o;
      end
      we_cnt = we_cnt + 1;
      run    = run + 1;
    end else begin
      run = 0;
    end
    if (run > max_run) max_run = run;
    if (sda === 1'b0 && !ctrl_low) drove_cnt = drove_cnt + 1;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic busStart();
    ctrl_low = 1'b0; #Q;
    scl = 1'b1;      #Q;
    ctrl_low = 1'b1; #Q;
    scl = 1'b0;      #Q;
  endtask

  task automatic busStop();
    ctrl_low = 1'b1; #Q;
    scl = 1'b1;      #Q;
    ctrl_low = 1'b0; #(2*Q);
  endtask

  task automatic writeBit(input logic b);
    ctrl_low = ~b; #Q;
    scl = 1'b1;    #(2*Q);
    scl = 1'b0;    #Q;
  endtask

  task automatic readBit(output logic b);
    ctrl_low = 1'b0; #Q;
    scl = 1'b1;      #Q;
    b = sda;         #Q;
    scl = 1'b0;      #Q;
  endtask

  task automatic sendByte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(v[i]);
    readBit(ack);
  endtask

  task automatic recvByte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      d[i] = b;
    end
    writeBit(nack);
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    int         w0;
    int         d0;

    rst = 1'b1; scl = 1'b1; ctrl_low = 1'b0; assigned = 7'h7F;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hBE] = 8'hA5;
    mem[8'h05] = 8'h10;
    mem[8'h06] = 8'h20;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_addr",  rif.reg_addr_o,  8'h00);
    checkOutput("reset_wdata", rif.reg_wdata_o, 8'h00);
    checkOutput("reset_we",    rif.reg_we_o,    1'b0);
    checkOutput("reset_addrd", rif.addressed_o, 1'b0);
    checkOutput("reset_sda",   sda,             1'b1);
    @(negedge clk) rst = 1'b0;
    #(4*Q);

    $display("[TB] address mismatch");
    w0 = we_cnt; d0 = drove_cnt;
    busStart();
    sendByte(8'h91, ack);
    checkOutput("mm_nack",  ack, 1'b1);
    checkOutput("mm_addrd", rif.addressed_o, 1'b0);
    busStop();
    checkOutput("mm_drove", drove_cnt - d0, 0);
    checkOutput("mm_we",    we_cnt - w0, 0);
    checkOutput("mm_sda",   sda, 1'b1);

    $display("[TB] single write");
    assigned = 7'h37;
    w0 = we_cnt;
    busStart();
    sendByte(8'h6E, ack); checkOutput("wr_ack_a", ack, 1'b0);
    checkOutput("wr_addrd", rif.addressed_o, 1'b1);
    sendByte(8'hDE, ack); checkOutput("wr_ack_p", ack, 1'b0);
    sendByte(8'hEE, ack); checkOutput("wr_ack_d", ack, 1'b0);
    busStop();
    checkOutput("wr_count", we_cnt - w0, 1);
    checkOutput("wr_saddr", log_addr[w0], 8'hDE);
    checkOutput("wr_sdata", log_data[w0], 8'hEE);
    checkOutput("wr_width", max_run, 1);
    checkOutput("wr_ptr",   rif.reg_addr_o, 8'hDF);
    checkOutput("wr_addrd_end", rif.addressed_o, 1'b0);

    $display("[TB] wrap write");
    w0 = we_cnt;
    busStart();
    sendByte(8'h6E, ack);
    sendByte(8'hFF, ack);
    sendByte(8'h11, ack);
    sendByte(8'h22, ack); checkOutput("wrap_ack", ack, 1'b0);
    busStop();
    checkOutput("wrap_count",  we_cnt - w0, 2);
    checkOutput("wrap_saddr0", log_addr[w0], 8'hFF);
    checkOutput("wrap_sdata0", log_data[w0], 8'h11);
    checkOutput("wrap_saddr1", log_addr[w0+1], 8'h00);
    checkOutput("wrap_sdata1", log_data[w0+1], 8'h22);
    checkOutput("wrap_ptr",    rif.reg_addr_o, 8'h01);

    $display("[TB] read with repeated start");
    busStart();
    sendByte(8'h6E, ack);
    sendByte(8'hBE, ack);
    busStart();
    sendByte(8'h6F, ack); checkOutput("rd_ack_a", ack, 1'b0);
    recvByte(d, 1'b1);
    checkOutput("rd_data", d, 8'hA5);
    busStop();
    checkOutput("rd_ptr", rif.reg_addr_o, 8'hBF);
    checkOutput("rd_sda", sda, 1'b1);

    $display("[TB] multi-byte read");
    busStart();
    sendByte(8'h6E, ack);
    sendByte(8'h05, ack);
    busStart();
    sendByte(8'h6F, ack);
    recvByte(d, 1'b0); checkOutput("mrd_data0", d, 8'h10);
    recvByte(d, 1'b1); checkOutput("mrd_data1", d, 8'h20);
    busStop();
    checkOutput("mrd_ptr",   rif.reg_addr_o, 8'h07);
    checkOutput("mrd_sda",   sda, 1'b1);
    checkOutput("mrd_addrd", rif.addressed_o, 1'b0);

    $display("[TB] reset mid-read");
    busStart();
    sendByte(8'h6E, ack);
    sendByte(8'h40, ack);
    busStart();
    sendByte(8'h6F, ack);
    readBit(b);
    checkOutput("rst_bit7", b, 1'b0);
    checkOutput("rst_pre_drive", sda, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_sda",   sda, 1'b1);
    checkOutput("rst_addr",  rif.reg_addr_o, 8'h00);
    checkOutput("rst_wdata", rif.reg_wdata_o, 8'h00);
    checkOutput("rst_we",    rif.reg_we_o, 1'b0);
    checkOutput("rst_addrd", rif.addressed_o, 1'b0);
    @(negedge clk) rst = 1'b0;
    busStop();

    $display("[TB] start aborts partial write");
    w0 = we_cnt;
    busStart();
    sendByte(8'h6E, ack);
    sendByte(8'h10, ack);
    writeBit(1'b0); writeBit(1'b1); writeBit(1'b0); writeBit(1'b1);
    busStart();
    checkOutput("abort_no_we", we_cnt - w0, 0);
    sendByte(8'h6E, ack); checkOutput("abort_ack_a", ack, 1'b0);
    sendByte(8'h20, ack);
    sendByte(8'h77, ack); checkOutput("abort_ack_d", ack, 1'b0);
    busStop();
    checkOutput("abort_count", we_cnt - w0, 1);
    checkOutput("abort_saddr", log_addr[w0], 8'h20);
    checkOutput("abort_sdata", log_data[w0], 8'h77);
    checkOutput("abort_ptr",   rif.reg_addr_o, 8'h21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
